// File: rtl/pc_ctrl_pkg.sv
// Shared encodings for the PC-source sequencer: request ops, PC-source selects,
// FSM states and the exception vector base.
package pc_ctrl_pkg;

    localparam int unsigned OP_W   = 3;
    localparam int unsigned SEL_W  = 3;
    localparam int unsigned CODE_W = 2;
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned CNT_W  = 3;

    localparam logic [OP_W-1:0] OP_SEQ    = 3'b000;
    localparam logic [OP_W-1:0] OP_BRANCH = 3'b001;
    localparam logic [OP_W-1:0] OP_JUMP   = 3'b010;
    localparam logic [OP_W-1:0] OP_JR     = 3'b011;
    localparam logic [OP_W-1:0] OP_RTE    = 3'b100;
    localparam logic [OP_W-1:0] OP_EXC    = 3'b101;

    localparam logic [SEL_W-1:0] SRC_ULA    = 3'b000;
    localparam logic [SEL_W-1:0] SRC_ALUOUT = 3'b001;
    localparam logic [SEL_W-1:0] SRC_CONCAT = 3'b010;
    localparam logic [SEL_W-1:0] SRC_MDR    = 3'b011;
    localparam logic [SEL_W-1:0] SRC_EPC    = 3'b100;

    localparam int unsigned VEC_BASE = 253;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        UPDATE  = 3'd1,
        EXC_EPC = 3'd2,
        EXC_RD  = 3'd3,
        EXC_LD  = 3'd4,
        EXC_PC  = 3'd5
    } state_e;

    // Cause 11 is unassigned and falls back to the opcode vector.
    function automatic logic [ADDR_W-1:0] vec_addr(input logic [CODE_W-1:0] code);
        logic [CODE_W-1:0] eff;
        eff = (code == 2'b11) ? 2'b00 : code;
        return ADDR_W'(VEC_BASE) + ADDR_W'(eff);
    endfunction

endpackage

// File: rtl/pc_source_ctrl.sv
// Sequences PC-source select, PC/EPC write enables and the exception-vector
// fetch for one PC-update request from main control.
module pc_source_ctrl
    import pc_ctrl_pkg::*;
#(
    parameter int unsigned MEM_WAIT = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [OP_W-1:0]   op,
    input  logic              branch_cond,
    input  logic [CODE_W-1:0] exc_code,
    output logic [SEL_W-1:0]  mux_pc_source_control,
    output logic              pc_write,
    output logic              epc_write,
    output logic              mem_read,
    output logic [ADDR_W-1:0] vector_addr,
    output logic              mdr_write,
    output logic              busy,
    output logic              done,
    output logic              illegal
);

    state_e              state_q, state_d;
    logic [OP_W-1:0]     op_q, op_d;
    logic                cond_q, cond_d;
    logic [CODE_W-1:0]   code_q, code_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;

    logic [SEL_W-1:0]    sel_q, sel_d;
    logic                pw_q, pw_d;
    logic                epw_q, epw_d;
    logic                mr_q, mr_d;
    logic [ADDR_W-1:0]   vec_q, vec_d;
    logic                mw_q, mw_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                ill_q, ill_d;

    // Next state and captures; outputs are decoded from the next state so the
    // registered outputs line up with the state they belong to.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        cond_d  = cond_q;
        code_d  = code_q;
        cnt_d   = cnt_q;
        sel_d   = SRC_ULA;
        pw_d    = 1'b0;
        epw_d   = 1'b0;
        mr_d    = 1'b0;
        vec_d   = '0;
        mw_d    = 1'b0;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        ill_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    op_d    = op;
                    cond_d  = branch_cond;
                    code_d  = exc_code;
                    state_d = (op == OP_EXC) ? EXC_EPC : UPDATE;
                end
            end
            UPDATE:  state_d = IDLE;
            EXC_EPC: begin
                state_d = EXC_RD;
                cnt_d   = CNT_W'(MEM_WAIT - 1);
            end
            EXC_RD: begin
                if (cnt_q == '0) state_d = EXC_LD;
                else             cnt_d   = cnt_q - 3'd1;
            end
            EXC_LD:  state_d = EXC_PC;
            EXC_PC:  state_d = IDLE;
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
        case (state_d)
            UPDATE: begin
                done_d = 1'b1;
                case (op_d)
                    OP_SEQ, OP_JR: pw_d = 1'b1;
                    OP_BRANCH: begin
                        sel_d = SRC_ALUOUT;
                        pw_d  = cond_d;
                    end
                    OP_JUMP: begin
                        sel_d = SRC_CONCAT;
                        pw_d  = 1'b1;
                    end
                    OP_RTE: begin
                        sel_d = SRC_EPC;
                        pw_d  = 1'b1;
                    end
                    default: ill_d = 1'b1;
                endcase
            end
            EXC_EPC: epw_d = 1'b1;
            EXC_RD: begin
                mr_d  = 1'b1;
                vec_d = vec_addr(code_d);
            end
            EXC_LD: begin
                mw_d  = 1'b1;
                vec_d = vec_addr(code_d);
            end
            EXC_PC: begin
                sel_d  = SRC_MDR;
                pw_d   = 1'b1;
                done_d = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            op_q    <= '0;
            cond_q  <= 1'b0;
            code_q  <= '0;
            cnt_q   <= '0;
            sel_q   <= SRC_ULA;
            pw_q    <= 1'b0;
            epw_q   <= 1'b0;
            mr_q    <= 1'b0;
            vec_q   <= '0;
            mw_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ill_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            cond_q  <= cond_d;
            code_q  <= code_d;
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
            pw_q    <= pw_d;
            epw_q   <= epw_d;
            mr_q    <= mr_d;
            vec_q   <= vec_d;
            mw_q    <= mw_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            ill_q   <= ill_d;
        end
    end

    assign mux_pc_source_control = sel_q;
    assign pc_write              = pw_q;
    assign epc_write             = epw_q;
    assign mem_read              = mr_q;
    assign vector_addr           = vec_q;
    assign mdr_write             = mw_q;
    assign busy                  = busy_q;
    assign done                  = done_q;
    assign illegal               = ill_q;

endmodule

// File: tb/tb_pc_source_ctrl.sv
// Directed bench for pc_source_ctrl: updates, exception entry, reset abort and
// held-start acceptance, checked against hand-computed output vectors.
module tb_pc_source_ctrl;

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic        branch_cond;
    logic [1:0]  exc_code;
    logic [2:0]  mux_pc_source_control;
    logic        pc_write;
    logic        epc_write;
    logic        mem_read;
    logic [31:0] vector_addr;
    logic        mdr_write;
    logic        busy;
    logic        done;
    logic        illegal;

    int n_vec = 0;
    int n_err = 0;

    pc_source_ctrl #(.MEM_WAIT(2)) dut (
        .clk                   (clk),
        .reset                 (reset),
        .start                 (start),
        .op                    (op),
        .branch_cond           (branch_cond),
        .exc_code              (exc_code),
        .mux_pc_source_control (mux_pc_source_control),
        .pc_write              (pc_write),
        .epc_write             (epc_write),
        .mem_read              (mem_read),
        .vector_addr           (vector_addr),
        .mdr_write             (mdr_write),
        .busy                  (busy),
        .done                  (done),
        .illegal               (illegal)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Packed view: {vector_addr, sel, pc_write, epc_write, mem_read, mdr_write, busy, done, illegal}
    function automatic logic [41:0] mk(input logic [2:0] sel, input logic pw, input logic epw,
                                       input logic mr, input logic mw, input logic bsy,
                                       input logic dn, input logic ill, input logic [31:0] va);
        return {va, sel, pw, epw, mr, mw, bsy, dn, ill};
    endfunction

    function automatic logic [41:0] obs();
        return {vector_addr, mux_pc_source_control, pc_write, epc_write, mem_read,
                mdr_write, busy, done, illegal};
    endfunction

    task automatic check(input string tag, input logic [41:0] got, input logic [41:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got va=%0d sel=%b pw/epw/mr/mw/busy/done/ill=%b, want va=%0d sel=%b pw/epw/mr/mw/busy/done/ill=%b",
                     tag, got[41:10], got[9:7], got[6:0], exp[41:10], exp[9:7], exp[6:0]);
        end
    endtask

    localparam logic [41:0] IDLE_V = 42'd0;

    // Pulse start during cycle 0; returns at the sample point of cycle 1.
    task automatic request(input logic [2:0] o, input logic c, input logic [1:0] code);
        op          = o;
        branch_cond = c;
        exc_code    = code;
        start       = 1'b1;
        @(negedge clk);
        start       = 1'b0;
    endtask

    task automatic exc_seq(input string tag, input logic [31:0] va);
        check({tag, "_c1_epc"}, obs(), mk(3'b000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0));
        @(negedge clk);
        check({tag, "_c2_rd"},  obs(), mk(3'b000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, va));
        @(negedge clk);
        check({tag, "_c3_rd"},  obs(), mk(3'b000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, va));
        @(negedge clk);
        check({tag, "_c4_ld"},  obs(), mk(3'b000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, va));
        @(negedge clk);
        check({tag, "_c5_pc"},  obs(), mk(3'b011, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'd0));
        @(negedge clk);
    endtask

    initial begin
        logic [2:0] sweep_op  [6];
        logic [2:0] sweep_sel [6];
        logic       sweep_pw  [6];
        logic       sweep_ill [6];
        sweep_op  = '{3'b000, 3'b010, 3'b011, 3'b100, 3'b110, 3'b111};
        sweep_sel = '{3'b000, 3'b010, 3'b000, 3'b100, 3'b000, 3'b000};
        sweep_pw  = '{1'b1,   1'b1,   1'b1,   1'b1,   1'b0,   1'b0};
        sweep_ill = '{1'b0,   1'b0,   1'b0,   1'b0,   1'b1,   1'b1};

        reset       = 1'b0;
        start       = 1'b0;
        op          = 3'b000;
        branch_cond = 1'b0;
        exc_code    = 2'b00;
        repeat (2) @(negedge clk);
        check("reset_state", obs(), IDLE_V);
        reset = 1'b1;
        @(negedge clk);
        check("idle_after_reset", obs(), IDLE_V);

        request(3'b001, 1'b0, 2'b00);
        check("branch_nt", obs(), mk(3'b001, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'd0));
        @(negedge clk);
        check("branch_nt_idle", obs(), IDLE_V);
        request(3'b001, 1'b1, 2'b00);
        check("branch_t", obs(), mk(3'b001, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'd0));
        @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            request(sweep_op[i], 1'b0, 2'b00);
            check($sformatf("op_%b", sweep_op[i]), obs(),
                  mk(sweep_sel[i], sweep_pw[i], 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, sweep_ill[i], 32'd0));
            @(negedge clk);
            check($sformatf("op_%b_idle", sweep_op[i]), obs(), IDLE_V);
        end

        request(3'b101, 1'b0, 2'b01);
        exc_seq("exc01", 32'd254);
        check("exc01_idle", obs(), IDLE_V);
        request(3'b101, 1'b0, 2'b11);
        exc_seq("exc11", 32'd253);
        request(3'b101, 1'b0, 2'b10);
        exc_seq("exc10", 32'd255);

        // Reset during the vector read aborts the sequence.
        request(3'b101, 1'b0, 2'b10);
        @(negedge clk);
        check("abort_in_rd", obs(), mk(3'b000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'd255));
        reset = 1'b0;
        @(negedge clk);
        check("abort_rst1", obs(), IDLE_V);
        @(negedge clk);
        check("abort_rst2", obs(), IDLE_V);
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check($sformatf("abort_quiet%0d", i), obs(), IDLE_V);
        end

        // start held through an exception: ignored until the cycle after done.
        op          = 3'b101;
        exc_code    = 2'b01;
        start       = 1'b1;
        @(negedge clk);
        check("hold_c1_epc", obs(), mk(3'b000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0));
        @(negedge clk);
        check("hold_c2_rd", obs(), mk(3'b000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'd254));
        @(negedge clk);
        check("hold_c3_rd", obs(), mk(3'b000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'd254));
        @(negedge clk);
        check("hold_c4_ld", obs(), mk(3'b000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'd254));
        @(negedge clk);
        check("hold_c5_pc", obs(), mk(3'b011, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'd0));
        @(negedge clk);
        check("hold_c6_idle", obs(), IDLE_V);
        exc_code = 2'b10;
        @(negedge clk);
        start = 1'b0;
        exc_seq("hold_second", 32'd255);
        check("hold_second_idle", obs(), IDLE_V);

        // Back-to-back sequential updates every two cycles.
        op    = 3'b000;
        start = 1'b1;
        @(negedge clk);
        check("b2b_1", obs(), mk(3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'd0));
        @(negedge clk);
        check("b2b_gap", obs(), IDLE_V);
        op = 3'b010;
        @(negedge clk);
        start = 1'b0;
        check("b2b_2", obs(), mk(3'b010, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'd0));
        @(negedge clk);
        check("b2b_end", obs(), IDLE_V);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
